// File: rtl/tickgen_pkg.sv
// ---------------------------------------------------------------------------
// tickgen_pkg
//   Shared definitions for the multi-channel tick generator.
//   - CNT_W_DEF   : default counter/divisor width
//   - ch_idx_w()  : width of a channel index (never less than 1 bit)
//   - ch_state_t  : per-channel state record {cnt, div, shadow, pending}
//                   at the default width
// ---------------------------------------------------------------------------
package tickgen_pkg;

    localparam int CNT_W_DEF = 32;

    // Width needed to address num_ch channels; a single channel still gets
    // one index bit so the write port is never zero-width.
    function automatic int ch_idx_w(input int num_ch);
        if (num_ch <= 2) begin
            return 1;
        end else begin
            return $clog2(num_ch);
        end
    endfunction

    // Channel state record. The channel module declares the same layout at
    // its own CNT_W.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] cnt;
        logic [CNT_W_DEF-1:0] div;
        logic [CNT_W_DEF-1:0] shadow;
        logic                 pending;
    } ch_state_t;

endpackage

// File: rtl/tick_channel.sv
// ---------------------------------------------------------------------------
// tick_channel
//   One tick-generator channel: counter, active divisor, shadow divisor with
//   pending flag, registered tick, and (with TICKGEN_TOGGLE_OUT_EN) a toggle
//   output that inverts on every tick.
// Ports
//   clk_i      board clock
//   rst_ni     asynchronous active-low reset
//   enable_i   count enable
//   clear_i    synchronous restart of the count
//   wr_i       validated divisor write for this channel
//   wr_val_i   divisor value to load into the shadow register
//   tick_o     registered one-cycle tick
//   tgl_o      square wave, period 2*div (TICKGEN_TOGGLE_OUT_EN only)
// ---------------------------------------------------------------------------
module tick_channel
    import tickgen_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             wr_i,
    input  logic [CNT_W-1:0] wr_val_i,
`ifdef TICKGEN_TOGGLE_OUT_EN
    output logic             tgl_o,
`endif
    output logic             tick_o
);

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] shadow;
        logic             pending;
    } state_t;

    state_t state_q, state_d;
    logic   tick_q, tick_d;
    logic   terminal_s;
    logic   apply_s;

    // div is never 0 (reset value >= 1, zero writes are rejected), so div-1
    // cannot wrap and cnt < div always holds.
    assign terminal_s = (state_q.cnt == (state_q.div - CNT_W'(1)));

    // A shadow divisor may only take effect at a period boundary: wrap,
    // clear, or while disabled.
    assign apply_s = clear_i | ~enable_i | terminal_s;

    // Next-state: counter priority (clear > disable > wrap > count), then
    // divisor hand-over, then shadow load.
    always_comb begin
        state_d = state_q;
        tick_d  = 1'b0;

        if (clear_i) begin
            state_d.cnt = '0;
        end else if (!enable_i) begin
            state_d.cnt = state_q.cnt;
        end else if (terminal_s) begin
            state_d.cnt = '0;
            tick_d      = 1'b1;
        end else begin
            state_d.cnt = state_q.cnt + CNT_W'(1);
        end

        if (apply_s && state_q.pending) begin
            state_d.div     = state_q.shadow;
            state_d.pending = 1'b0;
        end else begin
            state_d.div     = state_q.div;
        end

        // A write on the same edge as a hand-over re-arms pending, so the
        // new value waits for the following boundary.
        if (wr_i) begin
            state_d.shadow  = wr_val_i;
            state_d.pending = 1'b1;
        end else begin
            state_d.shadow  = state_q.shadow;
        end
    end

    // Channel state and tick registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q.cnt     <= '0;
            state_q.div     <= RST_DIV;
            state_q.shadow  <= '0;
            state_q.pending <= 1'b0;
            tick_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;

`ifdef TICKGEN_TOGGLE_OUT_EN
    logic tgl_q, tgl_d;

    // Toggle next-state: cleared by clear, inverted on each registered tick.
    always_comb begin
        tgl_d = tgl_q;
        if (clear_i) begin
            tgl_d = 1'b0;
        end else if (tick_d) begin
            tgl_d = ~tgl_q;
        end else begin
            tgl_d = tgl_q;
        end
    end

    // Toggle register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tgl_q <= 1'b0;
        end else begin
            tgl_q <= tgl_d;
        end
    end

    assign tgl_o = tgl_q;
`endif

endmodule

// File: rtl/multi_tick_generator.sv
// ---------------------------------------------------------------------------
// multi_tick_generator
//   NUM_CH independent tick channels, each emitting a one-cycle tick every
//   div clocks, with a runtime divisor write port shared by all channels.
//   Optional feature macro: TICKGEN_TOGGLE_OUT_EN adds the tgl output.
// Ports
//   clk      board clock, rising edge
//   rst      asynchronous active-low reset
//   enable   per-channel count enable
//   clear    per-channel synchronous restart
//   div_wr   divisor write strobe
//   div_ch   target channel of the write
//   div_val  new divisor value
//   div_err  one-cycle pulse when a write is rejected
//   tick     per-channel registered tick
//   tgl      per-channel square wave (TICKGEN_TOGGLE_OUT_EN only)
// ---------------------------------------------------------------------------
module multi_tick_generator
    import tickgen_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = CLK_FREQ_HZ,
    localparam int         CH_W        = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] clear,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_err,
`ifdef TICKGEN_TOGGLE_OUT_EN
    output logic [NUM_CH-1:0] tgl,
`endif
    output logic [NUM_CH-1:0] tick
);

    // A zero reset divisor would stall a channel; fall back to the board
    // frequency (1 s), and to 1 if that is also zero.
    localparam int unsigned RST_DIV_INT = (DEFAULT_DIV != 32'd0) ? DEFAULT_DIV :
                                          ((CLK_FREQ_HZ != 32'd0) ? CLK_FREQ_HZ : 32'd1);
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RST_DIV_INT);

    logic              wr_ok_s;
    logic [NUM_CH-1:0] ch_wr_s;
    logic              div_err_q, div_err_d;

    // Write validation and one-hot channel decode.
    always_comb begin
        wr_ok_s   = div_wr && (div_val != '0) && (32'(div_ch) < 32'(NUM_CH));
        div_err_d = div_wr & ~wr_ok_s;
        ch_wr_s   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr_s[i] = wr_ok_s && (div_ch == CH_W'(i));
        end
    end

    // Rejected-write pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_err_q <= 1'b0;
        end else begin
            div_err_q <= div_err_d;
        end
    end

    assign div_err = div_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .CNT_W   (CNT_W),
            .RST_DIV (RST_DIV)
        ) u_ch (
            .clk_i    (clk),
            .rst_ni   (rst),
            .enable_i (enable[g]),
            .clear_i  (clear[g]),
            .wr_i     (ch_wr_s[g]),
            .wr_val_i (div_val),
`ifdef TICKGEN_TOGGLE_OUT_EN
            .tgl_o    (tgl[g]),
`endif
            .tick_o   (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_tick_generator.sv
// ---------------------------------------------------------------------------
// tb_multi_tick_generator
//   Directed bench: 3 channels, 16-bit counters, reset divisor 5.
//   Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_multi_tick_generator;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 2;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] clear;
    logic              div_wr;
    logic [CH_W-1:0]   div_ch;
    logic [CNT_W-1:0]  div_val;
    logic              div_err;
    logic [NUM_CH-1:0] tick;
`ifdef TICKGEN_TOGGLE_OUT_EN
    logic [NUM_CH-1:0] tgl;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    multi_tick_generator #(
        .CLK_FREQ_HZ (5),
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .clear   (clear),
        .div_wr  (div_wr),
        .div_ch  (div_ch),
        .div_val (div_val),
        .div_err (div_err),
`ifdef TICKGEN_TOGGLE_OUT_EN
        .tgl     (tgl),
`endif
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b0;
        enable  = '0;
        clear   = '0;
        div_wr  = 1'b0;
        div_ch  = '0;
        div_val = '0;

        // Reset state
        step();
        step();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_err", 32'(div_err), 32'd0);
        rst = 1'b1;

        // ch0 at reset divisor 5: ticks on edges 5, 10, 15
        enable = 3'b001;
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("t1_tick", 32'(tick), (k % 5 == 0) ? 32'd1 : 32'd0);
        end
        enable = 3'b000;

        // ch1 divisor 3 loaded while disabled
        div_wr  = 1'b1;
        div_ch  = 2'd1;
        div_val = 16'd3;
        step();
        chk("wr_ok_err", 32'(div_err), 32'd0);
        div_wr = 1'b0;
        step();

        // ch1 running at 3; write 7 during edge 5 -> ticks 3, 6, 13, 20
        enable = 3'b010;
        for (int k = 1; k <= 20; k++) begin
            div_wr  = (k == 5);
            div_val = 16'd7;
            step();
            chk("t2_tick", 32'(tick),
                (k == 3 || k == 6 || k == 13 || k == 20) ? 32'd2 : 32'd0);
        end
        div_wr = 1'b0;
        enable = 3'b000;

        // Rejected writes: zero value, then out-of-range channel
        div_wr  = 1'b1;
        div_ch  = 2'd1;
        div_val = 16'd0;
        step();
        chk("err_zero", 32'(div_err), 32'd1);
        div_ch  = 2'd3;
        div_val = 16'd2;
        step();
        chk("err_chan", 32'(div_err), 32'd1);
        div_wr = 1'b0;
        step();
        chk("err_pulse_end", 32'(div_err), 32'd0);

        // ch1 period still 7
        enable = 3'b010;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("t3_tick", 32'(tick), (k == 7) ? 32'd2 : 32'd0);
        end
        enable = 3'b000;

        // ch2 div 5: clear on terminal edge 5 suppresses tick, next at 10
        enable = 3'b100;
        for (int k = 1; k <= 10; k++) begin
            clear = (k == 5) ? 3'b100 : 3'b000;
            step();
            chk("t4_tick", 32'(tick), (k == 10) ? 32'd4 : 32'd0);
        end
        clear = 3'b000;

        // ch2 paused on edges 13..16 -> tick moves from 15 to 19
        for (int k = 11; k <= 19; k++) begin
            enable = (k >= 13 && k <= 16) ? 3'b000 : 3'b100;
            step();
            chk("t5_tick", 32'(tick), (k == 19) ? 32'd4 : 32'd0);
        end

        // Asynchronous reset while a tick is high
        rst = 1'b0;
        #1;
        chk("t6_async_tick", 32'(tick), 32'd0);
        step();
        chk("t6_rst_err", 32'(div_err), 32'd0);
        rst    = 1'b1;
        enable = 3'b010;
        // ch1 back at reset divisor 5
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t6_tick", 32'(tick), (k == 5) ? 32'd2 : 32'd0);
        end
        enable = 3'b000;

        // Back-to-back writes to ch0: last one (4) wins
        div_wr  = 1'b1;
        div_ch  = 2'd0;
        div_val = 16'd9;
        step();
        div_val = 16'd4;
        step();
        div_wr = 1'b0;
        step();

        // ch0 div 4: ticks every 4, tgl period 8
        enable = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("t7_tick", 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
`ifdef TICKGEN_TOGGLE_OUT_EN
            chk("t7_tgl", 32'(tgl), ((k / 4) % 2 == 1) ? 32'd1 : 32'd0);
`endif
        end
        clear = 3'b001;
        step();
        chk("t7_clr_tick", 32'(tick), 32'd0);
`ifdef TICKGEN_TOGGLE_OUT_EN
        chk("t7_clr_tgl", 32'(tgl), 32'd0);
`endif
        clear  = 3'b000;
        enable = 3'b000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
